// File: rtl/led_pattern_pkg.sv
// Shared types and constants for the LED pattern controller.
package led_pattern_pkg;

    localparam int unsigned LED_W = 4;

    typedef enum logic [1:0] {
        BLINK = 2'd0,
        SHL   = 2'd1,
        SHR   = 2'd2,
        COUNT = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        LOAD = 2'd2
    } state_e;

    localparam logic [LED_W-1:0] RESET_PATTERN = 4'b1010;
    localparam logic [LED_W-1:0] SEED_BLINK    = 4'b1010;
    localparam logic [LED_W-1:0] SEED_SHL      = 4'b0001;
    localparam logic [LED_W-1:0] SEED_SHR      = 4'b1000;
    localparam logic [LED_W-1:0] SEED_COUNT    = 4'b0000;

    function automatic logic [LED_W-1:0] seed_of(input mode_e m);
        case (m)
            BLINK:   return SEED_BLINK;
            SHL:     return SEED_SHL;
            SHR:     return SEED_SHR;
            default: return SEED_COUNT;
        endcase
    endfunction

    // Plain (non-bouncing) next pattern for one tick.
    function automatic logic [LED_W-1:0] step_pattern(input mode_e m, input logic [LED_W-1:0] d);
        case (m)
            BLINK:   return ~d;
            SHL:     return {d[2:0], d[3]};
            SHR:     return {d[0], d[3:1]};
            default: return d + LED_W'(1);
        endcase
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// N-bit prescaler: counts while enabled, tick_c on the terminal count, then wraps.
module led_tick_gen #(
    parameter int unsigned N = 22
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick_c
);

    logic [N-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + N'(1);
        end
    end

    assign tick_c = en && (count == {N{1'b1}});

endmodule

// File: rtl/led_pattern_ctrl.sv
// LED pattern engine: mode handshake, seed load, per-tick pattern advance.
// Define LED_PATTERN_BOUNCE_EN to make SHL/SHR ping-pong instead of rotate.
module led_pattern_ctrl
    import led_pattern_pkg::*;
#(
    parameter int unsigned N = 22
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] mode_in,
    input  logic       mode_valid,
    output logic       mode_ready,
    input  logic       run,
    output logic [3:0] data,
    output logic       step,
    output logic [1:0] mode_cur
);

    state_e           state;
    mode_e            mode_q;
    logic             tick_c;
    logic             accept_c;
    logic [LED_W-1:0] data_nxt;
`ifdef LED_PATTERN_BOUNCE_EN
    logic             dir_left;
    logic             dir_nxt;
`endif

    assign accept_c = mode_valid && mode_ready;
    assign mode_cur = mode_q;

    led_tick_gen #(.N(N)) u_tick (
        .clk    (clk),
        .rst    (rst),
        .en     (state == RUN),
        .clr    (state == LOAD),
        .tick_c (tick_c)
    );

    // Pattern value to commit on the next applied tick.
    always_comb begin
        data_nxt = step_pattern(mode_q, data);
`ifdef LED_PATTERN_BOUNCE_EN
        dir_nxt = dir_left;
        if (mode_q == SHL || mode_q == SHR) begin
            if (dir_left) begin
                if (data[3]) begin
                    dir_nxt  = 1'b0;
                    data_nxt = {1'b0, data[3:1]};
                end else begin
                    data_nxt = {data[2:0], 1'b0};
                end
            end else begin
                if (data[0]) begin
                    dir_nxt  = 1'b1;
                    data_nxt = {data[2:0], 1'b0};
                end else begin
                    data_nxt = {1'b0, data[3:1]};
                end
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            mode_q     <= BLINK;
            data       <= RESET_PATTERN;
            step       <= 1'b0;
            mode_ready <= 1'b0;
`ifdef LED_PATTERN_BOUNCE_EN
            dir_left   <= 1'b1;
`endif
        end else begin
            step <= 1'b0;
            case (state)
                IDLE: begin
                    if (run) state <= RUN;
                end
                RUN: begin
                    // An accepted mode in the same cycle discards the tick.
                    if (tick_c && !accept_c) begin
                        data <= data_nxt;
                        step <= 1'b1;
`ifdef LED_PATTERN_BOUNCE_EN
                        dir_left <= dir_nxt;
`endif
                    end
                    if (!run) state <= IDLE;
                end
                LOAD: begin
                    data  <= seed_of(mode_q);
                    state <= run ? RUN : IDLE;
`ifdef LED_PATTERN_BOUNCE_EN
                    dir_left <= (mode_q != SHR);
`endif
                end
                default: state <= IDLE;
            endcase
            if (accept_c) begin
                mode_q <= mode_e'(mode_in);
                state  <= LOAD;
            end
            // Only LOAD blocks new requests, and LOAD follows every accept.
            mode_ready <= !accept_c;
        end
    end

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Randomized bench for led_pattern_ctrl against a cycle-level behavioural model.
module tb_led_pattern_ctrl;

    localparam int unsigned N    = 2;
    localparam int          TMAX = (1 << N) - 1;
    localparam int          S_IDLE = 0, S_RUN = 1, S_LOAD = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] mode_in;
    logic       mode_valid;
    logic       mode_ready;
    logic       run;
    logic [3:0] data;
    logic       step;
    logic [1:0] mode_cur;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    int m_state, m_cnt, m_data, m_mode, m_ready, m_step, m_dir;

    always #5 clk = ~clk;

    led_pattern_ctrl #(.N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .mode_in    (mode_in),
        .mode_valid (mode_valid),
        .mode_ready (mode_ready),
        .run        (run),
        .data       (data),
        .step       (step),
        .mode_cur   (mode_cur)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int seed_val(input int m);
        case (m)
            0:       return 10;
            1:       return 1;
            2:       return 8;
            default: return 0;
        endcase
    endfunction

    // Next pattern from the mode rules, using plain arithmetic on 0..15.
    task automatic advance(input int m, inout int d, inout int dir);
`ifdef LED_PATTERN_BOUNCE_EN
        if (m == 1 || m == 2) begin
            if (dir == 1) begin
                if (d == 8) begin d = 4; dir = 0; end
                else d = d * 2;
            end else begin
                if (d == 1) begin d = 2; dir = 1; end
                else d = d / 2;
            end
            return;
        end
`endif
        case (m)
            0:       d = 15 - d;
            1:       d = (d * 2) % 16 + d / 8;
            2:       d = d / 2 + (d % 2) * 8;
            default: d = (d + 1) % 16;
        endcase
    endtask

    task automatic model_edge();
        int acc, tick, nxt, nstep;
        if (rst) begin
            m_state = S_IDLE; m_cnt = 0; m_data = 10; m_mode = 0;
            m_ready = 0; m_step = 0; m_dir = 1;
            return;
        end
        acc   = (mode_valid && m_ready) ? 1 : 0;
        tick  = (m_state == S_RUN && m_cnt == TMAX) ? 1 : 0;
        nstep = 0;
        nxt   = run ? S_RUN : S_IDLE;
        if (m_state == S_LOAD) begin
            m_data = seed_val(m_mode);
            m_cnt  = 0;
            m_dir  = (m_mode == 2) ? 0 : 1;
        end else if (m_state == S_RUN) begin
            m_cnt = (m_cnt + 1) % (TMAX + 1);
            if (tick && !acc) begin
                advance(m_mode, m_data, m_dir);
                nstep = 1;
            end
        end
        if (acc) begin
            m_mode = int'(mode_in);
            nxt    = S_LOAD;
        end
        m_state = nxt;
        m_ready = (nxt != S_LOAD) ? 1 : 0;
        m_step  = nstep;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check("data",       int'(data),       m_data);
        check("step",       int'(step),       m_step);
        check("mode_ready", int'(mode_ready), m_ready);
        check("mode_cur",   int'(mode_cur),   m_mode);
    endtask

    task automatic request(input logic [1:0] m);
        mode_in = m; mode_valid = 1'b1;
        cycle();
        mode_valid = 1'b0;
    endtask

    initial begin
        int waited;
        rst = 1'b1; run = 1'b0; mode_in = 2'd0; mode_valid = 1'b0;
        m_state = S_IDLE; m_cnt = 0; m_data = 10; m_mode = 0;
        m_ready = 0; m_step = 0; m_dir = 1;
        repeat (2) cycle();
        rst = 1'b0;

        // Idle hold, then BLINK running
        repeat (20) cycle();
        run = 1'b1;
        repeat (12) cycle();

        // COUNT through a full wrap
        request(2'd3);
        repeat (70) cycle();

        // SHL rotation (or bounce)
        request(2'd1);
        repeat (30) cycle();

        // Accept exactly on a tick cycle, valid held through LOAD
        waited = 0;
        while (!(m_state == S_RUN && m_cnt == TMAX) && waited < 10) begin
            cycle();
            waited++;
        end
        check("tick_wait", waited < 10 ? 1 : 0, 1);
        mode_in = 2'd3; mode_valid = 1'b1;
        repeat (2) cycle();
        mode_valid = 1'b0;
        repeat (10) cycle();

        // Pause mid-count and resume
        run = 1'b0;
        repeat (5) cycle();
        run = 1'b1;
        repeat (6) cycle();

        // SHR then reset during RUN
        request(2'd2);
        repeat (14) cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        repeat (8) cycle();

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            rst        = ($urandom_range(99) == 0);
            run        = ($urandom_range(9) != 0);
            mode_valid = ($urandom_range(9) == 0);
            mode_in    = 2'($urandom_range(3));
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
